// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S capture path for the codec ADC.
//
// Oversamples the asynchronous codec bit clock in the clkin_50 domain, deserialises
// left/right words (MSB-first, one-bit I2S delay after each word-select edge) and
// buffers completed stereo pairs in a small FIFO read over a valid/ready handshake.
//
// Parameters
//   DATA_W      bits kept per channel; slot bits past DATA_W are ignored
//   FIFO_DEPTH  stereo pairs buffered (power of 2, >= 2)
//
// Ports
//   clkin_50      system clock, all logic on its rising edge
//   rst           synchronous active-high reset
//   enable        1 = capture, 0 = capture idle (FIFO still drains)
//   aud_bclk      codec bit clock (asynchronous)
//   aud_adc_lrck  codec word select, 0 = left, 1 = right (asynchronous)
//   aud_adc_dat   codec serial data (asynchronous)
//   sample_valid  FIFO non-empty
//   sample_ready  consumer pops the head pair when valid && ready
//   sample_left   head-of-FIFO left word (holds last value when empty)
//   sample_right  head-of-FIFO right word (holds last value when empty)
//   fifo_level    pairs stored, 0..FIFO_DEPTH
//   overflow      sticky flag: a completed pair was dropped because the FIFO was full
//   clear_ovf     one-cycle pulse clearing overflow (and ovf_count)
//   ovf_count     dropped-pair counter, saturating at 255
//
// Build option: define AUDIO_ADC_RX_OVF_CNT_EN to include the dropped-pair counter;
// without it ovf_count is tied to zero.

module audio_adc_rx #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clkin_50,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          aud_bclk,
  input  logic                          aud_adc_lrck,
  input  logic                          aud_adc_dat,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [DATA_W-1:0]             sample_left,
  output logic [DATA_W-1:0]             sample_right,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic [7:0]                    ovf_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned IdxW  = $clog2(DATA_W + 2);
  localparam int unsigned PairW = 2 * DATA_W;

  typedef enum logic [1:0] {StSyncWait, StLeft, StRight} state_e;

  // Input synchronisers and bit-clock edge detect
  logic bclk_meta_q, bclk_sync_q, bclk_prev_q;
  logic lrck_meta_q, lrck_sync_q;
  logic dat_meta_q, dat_sync_q;
  logic bclk_rise;

  // Deserialiser state
  state_e            state_q, state_d;
  logic              lrck_prev_q, lrck_prev_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d, idx_inc;
  logic [DATA_W-1:0] word_q, word_d, word_cap, fin_word;
  logic              word_done_q, word_done_d;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic [DATA_W-1:0] right_hold_q, right_hold_d;
  logic              left_ok_q, left_ok_d;
  logic              push_q, push_d;
  logic              slot_start, complete_left, complete_right;

  // FIFO state
  logic [PairW-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PairW-1:0]  head_q, head_d, push_data;
  logic              overflow_q, overflow_d;
  logic              pop, full, push_acc, drop;

  assign bclk_rise  = bclk_sync_q & ~bclk_prev_q;
  assign slot_start = bclk_rise && (lrck_sync_q != lrck_prev_q);

  always_comb begin
    idx_inc = (bit_idx_q == IdxW'(DATA_W + 1)) ? bit_idx_q : bit_idx_q + 1'b1;
    // Slot index k (1..DATA_W) lands in word bit DATA_W-k, i.e. MSB first
    word_cap = word_q;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (idx_inc == IdxW'(DATA_W - i)) word_cap[i] = dat_sync_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    lrck_prev_d    = bclk_rise ? lrck_sync_q : lrck_prev_q;
    bit_idx_d      = bit_idx_q;
    word_d         = word_q;
    word_done_d    = word_done_q;
    left_hold_d    = left_hold_q;
    right_hold_d   = right_hold_q;
    left_ok_d      = left_ok_q;
    push_d         = 1'b0;
    complete_left  = 1'b0;
    complete_right = 1'b0;
    fin_word       = word_q;

    if (!enable) begin
      state_d     = StSyncWait;
      left_ok_d   = 1'b0;
      bit_idx_d   = '0;
      word_d      = '0;
      word_done_d = 1'b1;
    end else if (slot_start) begin
      // Index 0 of a new slot carries the previous word's LSB; it is never captured.
      bit_idx_d   = '0;
      word_d      = '0;
      word_done_d = 1'b0;
      case (state_q)
        StSyncWait: if (!lrck_sync_q) state_d = StSyncWait == state_q ? StLeft : state_q;
        StLeft: begin
          if (lrck_sync_q) begin
            state_d       = StRight;
            complete_left = !word_done_q;  // short slot: missing LSBs stay 0
          end
        end
        StRight: begin
          if (!lrck_sync_q) begin
            state_d        = StLeft;
            complete_right = !word_done_q;
          end
        end
        default: state_d = StSyncWait;
      endcase
    end else if (bclk_rise) begin
      bit_idx_d = idx_inc;
      if (state_q != StSyncWait && !word_done_q && idx_inc != '0 &&
          idx_inc <= IdxW'(DATA_W)) begin
        word_d   = word_cap;
        fin_word = word_cap;
        if (idx_inc == IdxW'(DATA_W)) begin
          word_done_d    = 1'b1;
          complete_left  = (state_q == StLeft);
          complete_right = (state_q == StRight);
        end
      end
    end

    if (complete_left) begin
      left_hold_d = fin_word;
      left_ok_d   = 1'b1;
    end
    if (complete_right) begin
      right_hold_d = fin_word;
      push_d       = left_ok_q;
    end
  end

  // FIFO control
  assign push_data = {left_hold_q, right_hold_q};
  assign pop       = (count_q != '0) && sample_ready;
  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign push_acc  = push_q && (!full || pop);
  assign drop      = push_q && full && !pop;

  always_comb begin
    wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Head register tracks mem[rd_ptr] while non-empty and freezes when empty.
    head_d = head_q;
    if (push_acc && (count_q == '0 || (count_q == CntW'(1) && pop))) begin
      head_d = push_data;
    end else if (count_d != '0) begin
      head_d = mem_q[rd_ptr_d];
    end

    overflow_d = overflow_q;
    if (clear_ovf) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
  end

  always_ff @(posedge clkin_50) begin
    if (rst) begin
      bclk_meta_q  <= 1'b0;
      bclk_sync_q  <= 1'b0;
      bclk_prev_q  <= 1'b0;
      lrck_meta_q  <= 1'b0;
      lrck_sync_q  <= 1'b0;
      dat_meta_q   <= 1'b0;
      dat_sync_q   <= 1'b0;
      state_q      <= StSyncWait;
      lrck_prev_q  <= 1'b0;
      bit_idx_q    <= '0;
      word_q       <= '0;
      word_done_q  <= 1'b1;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      left_ok_q    <= 1'b0;
      push_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      bclk_meta_q  <= aud_bclk;
      bclk_sync_q  <= bclk_meta_q;
      bclk_prev_q  <= bclk_sync_q;
      lrck_meta_q  <= aud_adc_lrck;
      lrck_sync_q  <= lrck_meta_q;
      dat_meta_q   <= aud_adc_dat;
      dat_sync_q   <= dat_meta_q;
      state_q      <= state_d;
      lrck_prev_q  <= lrck_prev_d;
      bit_idx_q    <= bit_idx_d;
      word_q       <= word_d;
      word_done_q  <= word_done_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      left_ok_q    <= left_ok_d;
      push_q       <= push_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clkin_50) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_data;
  end

`ifdef AUDIO_ADC_RX_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clear_ovf) ovf_cnt_d = 8'd0;
    if (drop) begin
      if (clear_ovf)                ovf_cnt_d = 8'd1;
      else if (ovf_cnt_q != 8'hFF)  ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clkin_50) begin
    if (rst) ovf_cnt_q <= 8'd0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = 8'd0;
`endif

  assign sample_valid = (count_q != '0);
  assign fifo_level   = count_q;
  assign overflow     = overflow_q;
  assign sample_left  = head_q[PairW-1:DATA_W];
  assign sample_right = head_q[DATA_W-1:0];

endmodule

// File: tb/tb_audio_adc_rx.sv
// Testbench for audio_adc_rx: an I2S BFM (bclk = clkin_50/16) drives the codec pins,
// expected pairs go into a scoreboard queue as they are sent and a negedge monitor
// compares each popped pair against the queue head.

module tb_audio_adc_rx;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
  localparam logic [7:0] ExpOvfCnt = 8'd1;
`else
  localparam logic [7:0] ExpOvfCnt = 8'd0;
`endif

  logic          clkin_50 = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          aud_bclk = 1'b0;
  logic          aud_adc_lrck = 1'b1;
  logic          aud_adc_dat = 1'b0;
  logic          sample_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic          sample_valid;
  logic [DW-1:0] sample_left, sample_right;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic [7:0]    ovf_count;

  audio_adc_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clkin_50     (clkin_50),
    .rst          (rst),
    .enable       (enable),
    .aud_bclk     (aud_bclk),
    .aud_adc_lrck (aud_adc_lrck),
    .aud_adc_dat  (aud_adc_dat),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf),
    .ovf_count    (ovf_count)
  );

  always #10 clkin_50 = ~clkin_50;

  int unsigned   cyc = 0;
  always @(posedge clkin_50) cyc <= cyc + 1;

  int            errors = 0;
  int            checks = 0;
  int            pops = 0;
  int            lsb_cyc = 0;
  int            valid_rise_cyc = -1000;
  logic          valid_prev = 1'b0;
  logic [2*DW-1:0] exp_q[$];

  // Scoreboard monitor
  always @(negedge clkin_50) begin
    logic [2*DW-1:0] exp_pair;
    if (sample_valid && !valid_prev) valid_rise_cyc = int'(cyc);
    valid_prev = sample_valid;
    if (!rst && sample_valid && sample_ready) begin
      pops++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pair_unexpected: got %h_%h, required no pair", sample_left, sample_right);
      end else begin
        exp_pair = exp_q.pop_front();
        if ({sample_left, sample_right} !== exp_pair) begin
          errors++;
          $display("FAIL pair_data: got %h_%h, required %h_%h", sample_left, sample_right,
                   exp_pair[2*DW-1:DW], exp_pair[DW-1:0]);
        end
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clkin_50);
    #1;
  endtask

  // One bit period: pins change at the bclk fall, captured on the rise.
  task automatic bfm_bit(input logic lr, input logic d, input logic mark);
    aud_bclk     = 1'b0;
    aud_adc_lrck = lr;
    aud_adc_dat  = d;
    clk_wait(8);
    aud_bclk = 1'b1;
    if (mark) lsb_cyc = int'(cyc);
    clk_wait(8);
  endtask

  // Slot of slot_len bits: index 0 is the (skipped) delay bit, driven 1 to expose a
  // missing skip; indices 1..nbits carry w MSB-first; the rest are 0.
  task automatic bfm_slot(input logic lr, input logic [DW-1:0] w, input int nbits,
                          input int slot_len, input logic mark_lsb);
    logic d;
    for (int i = 0; i < slot_len; i++) begin
      if (i == 0)          d = 1'b1;
      else if (i <= nbits) d = w[DW-i];
      else                 d = 1'b0;
      bfm_bit(lr, d, mark_lsb && (i == nbits));
    end
  endtask

  task automatic bfm_pair(input logic [DW-1:0] l, input logic [DW-1:0] r,
                          input logic expect_it, input logic mark);
    if (expect_it) exp_q.push_back({l, r});
    bfm_slot(1'b0, l, DW, 32, 1'b0);
    bfm_slot(1'b1, r, DW, 32, mark);
  endtask

  // Short right-channel run so the next left slot starts on a visible 1->0 edge.
  task automatic lead_in();
    bfm_slot(1'b1, '0, 0, 8, 1'b0);
  endtask

  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clkin_50);
      if (exp_q.size() == 0 && !sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
    clk_wait(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    clk_wait(4);
    @(negedge clkin_50);
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", sample_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf_count: got %0d, required 0", ovf_count); end
    checks++; if (sample_left !== 16'h0) begin errors++; $display("FAIL reset_left: got %h, required 0000", sample_left); end
    checks++; if (sample_right !== 16'h0) begin errors++; $display("FAIL reset_right: got %h, required 0000", sample_right); end
    clk_wait(1);
    rst = 1'b0;
    enable = 1'b1;
    clk_wait(2);
  endtask

  task automatic test_single_pair();
    bit ok;
    int p0, lat;
    p0 = pops;
    sample_ready = 1'b1;
    lead_in();
    bfm_pair(16'hA55A, 16'h0F0F, 1'b1, 1'b1);
    wait_empty(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL single_count: got %0d pairs, required 1", pops - p0); end
    lat = valid_rise_cyc - lsb_cyc;
    checks++; if (lat < 1 || lat > 5) begin errors++; $display("FAIL single_latency: got %0d cycles, required 1..5", lat); end
  endtask

  task automatic test_mid_slot_start();
    bit ok;
    int p0;
    rst = 1'b1;
    clk_wait(2);
    rst = 1'b0;
    clk_wait(2);
    p0 = pops;
    sample_ready = 1'b1;
    for (int i = 0; i < 12; i++) bfm_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    bfm_pair(16'h1234, 16'h8765, 1'b1, 1'b0);
    bfm_pair(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    wait_empty(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midslot_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (pops - p0 !== 2) begin errors++; $display("FAIL midslot_count: got %0d pairs, required 2", pops - p0); end
  endtask

  task automatic test_overflow();
    bit ok;
    int p0;
    sample_ready = 1'b0;
    lead_in();
    bfm_pair(16'h1111, 16'hEEEE, 1'b1, 1'b0);
    bfm_pair(16'h2222, 16'hDDDD, 1'b1, 1'b0);
    bfm_pair(16'h3333, 16'hCCCC, 1'b1, 1'b0);
    bfm_pair(16'h4444, 16'hBBBB, 1'b1, 1'b0);
    bfm_pair(16'h5555, 16'hAAAA, 1'b0, 1'b0);
    clk_wait(10);
    @(negedge clkin_50);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d, required 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    checks++; if (ovf_count !== ExpOvfCnt) begin errors++; $display("FAIL ovf_count: got %0d, required %0d", ovf_count, ExpOvfCnt); end
    checks++; if (sample_left !== 16'h1111) begin errors++; $display("FAIL ovf_head: got %h, required 1111", sample_left); end
    clk_wait(1);
    p0 = pops;
    sample_ready = 1'b1;
    wait_empty(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (pops - p0 !== 4) begin errors++; $display("FAIL ovf_drain_count: got %0d pairs, required 4", pops - p0); end
    clear_ovf = 1'b1;
    clk_wait(1);
    clear_ovf = 1'b0;
    @(negedge clkin_50);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL ovf_count_clear: got %0d, required 0", ovf_count); end
    clk_wait(1);
  endtask

  task automatic test_full_push_pop();
    bit ok, seen;
    int p0;
    sample_ready = 1'b0;
    p0 = pops;
    lead_in();
    bfm_pair(16'h0101, 16'h1010, 1'b1, 1'b0);
    bfm_pair(16'h0202, 16'h2020, 1'b1, 1'b0);
    bfm_pair(16'h0303, 16'h3030, 1'b1, 1'b0);
    bfm_pair(16'h0404, 16'h4040, 1'b1, 1'b0);
    seen = 1'b0;
    fork
      bfm_pair(16'h0505, 16'h5050, 1'b1, 1'b0);
      begin
        // Pop on exactly the cycle the completed pair is pushed into the full FIFO.
        for (int i = 0; i < 3000; i++) begin
          @(posedge clkin_50);
          #1;
          if (dut.push_q) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          sample_ready = 1'b1;
          clk_wait(1);
          sample_ready = 1'b0;
        end
      end
    join
    checks++; if (!seen) begin errors++; $display("FAIL fullpp_push_seen: got 0, required 1"); end
    clk_wait(5);
    @(negedge clkin_50);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpp_level: got %0d, required 4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow: got %b, required 0", overflow); end
    clk_wait(1);
    sample_ready = 1'b1;
    wait_empty(ok);
    checks++; if (!ok) begin errors++; $display("FAIL fullpp_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (pops - p0 !== 5) begin errors++; $display("FAIL fullpp_count: got %0d pairs, required 5", pops - p0); end
  endtask

  task automatic test_short_slot();
    bit ok;
    sample_ready = 1'b1;
    lead_in();
    exp_q.push_back({16'hFFC0, 16'h1234});
    // Left slot: delay bit plus 10 data bits of 10'h3FF, then lrck flips early.
    bfm_slot(1'b0, 16'hFFC0, 10, 11, 1'b0);
    bfm_slot(1'b1, 16'h1234, DW, 32, 1'b0);
    wait_empty(ok);
    @(negedge clkin_50);
    checks++; if (!ok) begin errors++; $display("FAIL short_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (sample_left !== 16'hFFC0) begin errors++; $display("FAIL short_left_hold: got %h, required ffc0", sample_left); end
    checks++; if (sample_right !== 16'h1234) begin errors++; $display("FAIL short_right_hold: got %h, required 1234", sample_right); end
    clk_wait(1);
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    int p0;
    logic [DW-1:0] junk;
    sample_ready = 1'b1;
    junk = 16'hC3A5;
    lead_in();
    bfm_bit(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) bfm_bit(1'b0, junk[DW-i], 1'b0);
    rst = 1'b1;
    clk_wait(2);
    rst = 1'b0;
    p0 = pops;
    for (int i = 9; i <= DW; i++) bfm_bit(1'b0, junk[DW-i], 1'b0);
    for (int i = DW + 1; i < 32; i++) bfm_bit(1'b0, 1'b0, 1'b0);
    bfm_slot(1'b1, 16'h5A5A, DW, 32, 1'b0);
    bfm_pair(16'hBEEF, 16'hCAFE, 1'b1, 1'b0);
    bfm_pair(16'h0F0F, 16'hF0F0, 1'b1, 1'b0);
    wait_empty(ok);
    @(negedge clkin_50);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_drain: got %0d pending, required 0", exp_q.size()); end
    checks++; if (pops - p0 !== 2) begin errors++; $display("FAIL rstmid_count: got %0d pairs, required 2", pops - p0); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rstmid_level: got %0d, required 0", fifo_level); end
    clk_wait(1);
  endtask

  initial begin
    clk_wait(1);
    test_reset();
    test_single_pair();
    test_mid_slot_start();
    test_overflow();
    test_full_push_pop();
    test_short_slot();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no completion, required finish within 5 ms");
    $fatal(1, "simulation time limit reached");
  end

endmodule
